// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: stall/branch in, decode bus and I-SRAM out.
// The fetch stage takes the master modport; the environment (decode, SRAM, bench) takes slave.
interface if_stage_if;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, br_bus,
    output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, fetch_cnt
  );
  modport slave (
    output stall, br_bus,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, fetch_cnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-SRAM read, forwards {ce, pc} to decode.
// Define IF_BR_PENDING_EN to remember a branch redirect that arrives while the PC is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic          clk,
  input  logic          rst,
  if_stage_if.master    bus
);

  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic        br_e;
  logic [31:0] br_addr;
  logic        stop;

  assign br_e    = bus.br_bus[32];
  assign br_addr = bus.br_bus[31:0];
  assign stop    = bus.stall[0];

`ifdef IF_BR_PENDING_EN
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ce_d        = ce_q;
    fetch_cnt_d = fetch_cnt_q;
`ifdef IF_BR_PENDING_EN
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
`endif
    if (!stop) begin
      state_d     = ST_RUN;
      ce_d        = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
`ifdef IF_BR_PENDING_EN
      pend_v_d    = 1'b0;
      if (br_e)          pc_d = br_addr;
      else if (pend_v_q) pc_d = pend_addr_q;
      else               pc_d = pc_q + 32'd4;
`else
      pc_d        = br_e ? br_addr : pc_q + 32'd4;
`endif
    end else begin
      // A stall before the first fetch keeps ce low; otherwise the PC simply freezes.
      state_d = (state_q == ST_RESET) ? ST_RESET : ST_HOLD;
`ifdef IF_BR_PENDING_EN
      if (br_e) begin
        pend_v_d    = 1'b1;
        pend_addr_d = br_addr;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      pc_q        <= RESET_PC;
      ce_q        <= 1'b0;
      fetch_cnt_q <= 32'd0;
`ifdef IF_BR_PENDING_EN
      pend_v_q    <= 1'b0;
      pend_addr_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      fetch_cnt_q <= fetch_cnt_d;
`ifdef IF_BR_PENDING_EN
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
`endif
    end
  end

  assign bus.if_to_id_bus    = {ce_q, pc_q};
  assign bus.inst_sram_en    = ce_q;
  assign bus.inst_sram_wen   = 4'b0000;
  assign bus.inst_sram_addr  = pc_q;
  assign bus.inst_sram_wdata = 32'd0;
  assign bus.fetch_cnt       = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, branch, stall, stalled redirect, reset override, wrap.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  if_stage_if bus_if ();
  if_stage #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic be, input logic [31:0] ba);
    rst              = r;
    bus_if.stall     = {5'b0, s};
    bus_if.br_bus    = {be, ba};
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] a, input logic en, input logic [31:0] cnt);
    chk({tag, ".addr"}, 64'(bus_if.inst_sram_addr), 64'(a));
    chk({tag, ".en"},   64'(bus_if.inst_sram_en),   64'(en));
    chk({tag, ".cnt"},  64'(bus_if.fetch_cnt),      64'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    bus_if.stall  = 6'b0;
    bus_if.br_bus = 33'b0;
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_pc("rst", RST_PC, 0, 0);
    chk("rst.bus",   64'(bus_if.if_to_id_bus), 64'({1'b0, RST_PC}));
    chk("rst.wen",   64'(bus_if.inst_sram_wen), 64'd0);
    chk("rst.wdata", 64'(bus_if.inst_sram_wdata), 64'd0);

    // sequential fetch
    step(0, 0, 0, 0); chk_pc("seq0", 32'hBFC0_0000, 1, 1);
    chk("seq0.bus", 64'(bus_if.if_to_id_bus), 64'({1'b1, 32'hBFC0_0000}));
    step(0, 0, 0, 0); chk_pc("seq1", 32'hBFC0_0004, 1, 2);
    step(0, 0, 0, 0); chk_pc("seq2", 32'hBFC0_0008, 1, 3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0); chk_pc("seq4", 32'hBFC0_0010, 1, 5);

    // one-cycle branch
    step(0, 0, 1, 32'hBFC0_0100); chk_pc("br",    32'hBFC0_0100, 1, 6);
    step(0, 0, 0, 0);             chk_pc("br+4",  32'hBFC0_0104, 1, 7);

    // stall for 3 cycles
    step(0, 0, 1, 32'hBFC0_0020); chk_pc("st.pre", 32'hBFC0_0020, 1, 8);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0); chk_pc($sformatf("st%0d", i), 32'hBFC0_0020, 1, 8);
    end
    step(0, 0, 0, 0); chk_pc("st.rel", 32'hBFC0_0024, 1, 9);

    // redirects arriving during a stall
    step(0, 0, 1, 32'hBFC0_0030); chk_pc("pd.pre", 32'hBFC0_0030, 1, 10);
    step(0, 1, 1, 32'hBFC0_0200); chk_pc("pd.s0",  32'hBFC0_0030, 1, 10);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'hBFC0_0300); chk_pc("pd.s2",  32'hBFC0_0030, 1, 10);
`ifdef IF_BR_PENDING_EN
    step(0, 0, 0, 0); chk_pc("pd.rel", 32'hBFC0_0300, 1, 11);
`else
    step(0, 0, 0, 0); chk_pc("pd.rel", 32'hBFC0_0034, 1, 11);
`endif

    // reset overrides branch and a pending redirect
    step(0, 1, 1, 32'hBFC0_0500);
    step(1, 0, 1, 32'hBFC0_0600); chk_pc("mrst", RST_PC, 0, 0);
    chk("mrst.bus", 64'(bus_if.if_to_id_bus), 64'({1'b0, RST_PC}));
    // stall out of reset keeps ce low
    step(0, 1, 0, 0); chk_pc("rst.st", RST_PC, 0, 0);
    step(0, 0, 0, 0); chk_pc("mrst.rel", 32'hBFC0_0000, 1, 1);

    // branch beats nothing pending; then PC wrap
    step(0, 0, 1, 32'hFFFF_FFFC); chk_pc("wrap.pre", 32'hFFFF_FFFC, 1, 2);
    step(0, 0, 0, 0);             chk_pc("wrap",     32'h0000_0000, 1, 3);
    chk("wrap.bus", 64'(bus_if.if_to_id_bus), 64'({1'b1, 32'h0000_0000}));
    // misaligned target passes through untouched
    step(0, 0, 1, 32'h0000_1003); chk_pc("misal", 32'h0000_1003, 1, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
